bcd_conv_sched: RTL

Round-robin scheduler that shares the single `res_to_bcd` converter among up to three requesters: ALU result, operand-entry echo and memory recall. It latches one request, drives the converter's start/operand inputs, and captures the BCD result. The converter leaves fractional digits stale in integer mode, so the scheduler clears them before returning the result with a one-cycle acknowledge. A watchdog turns a hung conversion into an error response.

---
 rtl/bcd_conv_sched_pkg.sv | 25 ++
 rtl/bcd_conv_sched_rr_arbiter.sv | 27 ++
 rtl/bcd_conv_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler: FSM encodings,
// converter opcodes and the fraction-field width helper.
package bcd_conv_sched_pkg;

  localparam int OUTPUTWIDTH = 32;

  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_LAUNCH = 3'd1,
    SCHED_WAIT   = 3'd2,
    SCHED_DRAIN  = 3'd3,
    SCHED_RESP   = 3'd4
  } sched_state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;

  // Fraction digits occupy the low bits below the sign and integer digits.
  function automatic int bcd_frac_lsb_w(input int bcd_width);
    return bcd_width - 32;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request above the last grant,
// wrapping around, so the most recently served requester ranks last.
module bcd_conv_sched_rr_arbiter #(
  parameter int N_REQ = 3
)(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_last,
  output logic             o_valid,
  output logic [1:0]       o_idx
);

  int w_idx;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(i_last) + k) % N_REQ;
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_idx   = 2'(w_idx);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one res_to_bcd converter among N_REQ requesters,
// with stale-fraction clearing, a WAIT watchdog and a one-cycle acknowledge.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int M         = OUTPUTWIDTH,
  parameter int BCD_WIDTH = 60,
  parameter int TIMEOUT   = 1023
)(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*M-1:0]     req_val,
  input  logic [N_REQ*4-1:0]     req_opcode,
  output logic [N_REQ-1:0]       ack,
  output logic [BCD_WIDTH-1:0]   rsp_bcd,
  output logic                   rsp_fixed,
  output logic                   rsp_signed,
  output logic [1:0]             rsp_id,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [M-1:0]           conv_val,
  output logic [3:0]             conv_opcode,
  output logic                   conv_ce,
  input  logic [BCD_WIDTH-1:0]   conv_bcd,
  input  logic                   conv_fixed,
  input  logic                   conv_signed,
  input  logic                   conv_done,
  output sched_state_t           o_dbg_state
);

  localparam int FRAC_W = bcd_frac_lsb_w(BCD_WIDTH);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  sched_state_t    r_state;
  logic [1:0]      r_last_grant;
  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  logic            w_grant_valid;
  logic [1:0]      w_grant_idx;

  assign o_dbg_state = r_state;

  bcd_conv_sched_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req   (req),
    .i_last  (r_last_grant),
    .o_valid (w_grant_valid),
    .o_idx   (w_grant_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= SCHED_IDLE;
      r_last_grant <= 2'(N_REQ - 1);
      r_wdog       <= '0;
      r_err        <= 1'b0;
      ack          <= '0;
      rsp_bcd      <= '0;
      rsp_fixed    <= 1'b0;
      rsp_signed   <= 1'b0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      conv_val     <= '0;
      conv_opcode  <= '0;
      conv_ce      <= 1'b0;
    end else begin
      ack     <= '0;
      conv_ce <= 1'b0;
      case (r_state)
        SCHED_IDLE: begin
          if (w_grant_valid) begin
            conv_val     <= req_val[w_grant_idx*M +: M];
            conv_opcode  <= req_opcode[w_grant_idx*4 +: 4];
            rsp_id       <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            conv_ce      <= 1'b1;
            busy         <= 1'b1;
            r_state      <= SCHED_LAUNCH;
          end
        end
        SCHED_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= SCHED_WAIT;
        end
        SCHED_WAIT: begin
          // Timeout wins over a done arriving on the same cycle.
          if (r_wdog == WD_W'(TIMEOUT)) begin
            r_err      <= 1'b1;
            rsp_bcd    <= '1;
            rsp_fixed  <= 1'b0;
            rsp_signed <= 1'b0;
            r_state    <= SCHED_DRAIN;
          end else if (conv_done) begin
            if (conv_fixed) begin
              rsp_bcd <= conv_bcd;
            end else begin
              rsp_bcd <= {conv_bcd[BCD_WIDTH-1:FRAC_W], {FRAC_W{1'b0}}};
            end
            rsp_fixed  <= conv_fixed;
            rsp_signed <= conv_signed;
            r_state    <= SCHED_DRAIN;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        SCHED_DRAIN: begin
          // Done is held two cycles; let it fall so it cannot finish the next job.
          if (!conv_done) begin
            ack     <= N_REQ'(1) << rsp_id;
            rsp_err <= r_err;
            r_state <= SCHED_RESP;
          end
        end
        SCHED_RESP: begin
          r_err   <= 1'b0;
          rsp_err <= 1'b0;
          busy    <= 1'b0;
          r_state <= SCHED_IDLE;
        end
        default: r_state <= SCHED_IDLE;
      endcase
    end
  end

endmodule
